sha256_core_arbiter: RTL
========================

Name: sha256_core_arbiter

Overview:
- Shares one SHA-256 single-block hash core between NUM_REQ requesters.
- Grants requesters round-robin and drives the core's 512-bit block input and one-cycle init pulse.
- The core has no done signal, so the block counts a fixed CORE_LATENCY cycles and then captures the 256-bit digest.
- Returns the digest and the requester ID on a valid/ready response channel.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CORE_LATENCY, 67, clk edges from the init-high cycle to the cycle in which core_hash holds the digest.
- ID_W, 2, width of rsp_id; must satisfy 2^ID_W >= NUM_REQ.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester block-valid
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero
- req_data  input  NUM_REQ*512  requester i's block is bits [i*512 +: 512]
- rsp_valid  output  1  digest valid
- rsp_ready  input  1  response consumer ready
- rsp_hash  output  256  digest
- rsp_id  output  ID_W  index of the requester that owns rsp_hash
- core_data  output  512  block to the core
- core_init  output  1  core start pulse, one cycle
- core_hash  input  256  core digest output
- busy  output  1  high in any state other than IDLE

Behaviour:
- All outputs are registered.
- Reset values: req_ready=0, rsp_valid=0, rsp_hash=0, rsp_id=0, core_data=0, core_init=0, busy=0, state=IDLE, rr_ptr=0, cnt=0.
- Reset mid-operation aborts any job with no response.
- The core is reset from the same reset signal.
- State machine:
  - IDLE:
    - If any req_valid is high, pick the first set bit searching upward from rr_ptr, wrapping from NUM_REQ-1 to 0.
    - Assert req_ready[g] for exactly one cycle (a registered one-cycle pulse; req_ready is deasserted on the next edge).
    - In the same edge, latch req_data[g] into core_data and g into a job_id register.
    - Set rr_ptr = g+1 mod NUM_REQ, then go to LAUNCH.
  - LAUNCH:
    - core_init=1 for this single cycle; cnt=0; go to WAIT.
  - WAIT:
    - cnt increments every cycle.
    - When cnt == CORE_LATENCY-1, capture core_hash into rsp_hash, set rsp_id = job_id and rsp_valid=1, then go to RESP.
  - RESP:
    - Hold rsp_valid, rsp_hash and rsp_id stable until rsp_valid && rsp_ready.
    - On that handshake, rsp_valid=0 on the next edge and go to IDLE.
- The earliest next grant is the cycle after the handshake.
- core_data is held constant from LAUNCH through RESP.
- core_init is never asserted outside LAUNCH.
- A requester must keep req_valid and req_data stable until it sees req_ready. req_valid dropping before the grant is legal; that requester is skipped.
- Simultaneous requests are resolved only by rr_ptr. A requester whose grant is pending is granted within NUM_REQ jobs.
- Wrap-around: after granting NUM_REQ-1, rr_ptr=0.
- Zero requests in IDLE: stay in IDLE; req_ready stays 0.
- Requests arriving during LAUNCH, WAIT or RESP are ignored until IDLE.
- rsp_ready asserted before rsp_valid has no effect.
- Throughput: one job per CORE_LATENCY+3 cycles minimum, when rsp_ready is held high.

Optional Feature:
- Macro SHA_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index valid requester always wins, and rr_ptr is not implemented.
- Undefined: round-robin as above.
- All other timing is identical in both builds.

Test Plan:
- Single job: reset, then req_valid=0001 with data = padded "abc" block (0x61626380, zeros, length 0x18).
  - Expect req_ready=0001 for 1 cycle and core_init for 1 cycle.
  - Expect rsp_valid after CORE_LATENCY+2 cycles with rsp_hash=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad and rsp_id=0.
- Round-robin: req_valid=1111 held with rsp_ready=1.
  - Expect grant order 0,1,2,3,0 and rsp_id sequence 0,1,2,3.
  - Under SHA_ARB_FIXED_PRIO_EN, expect grants 0,0,0.
- Back-pressure: rsp_ready=0 for 20 cycles after rsp_valid.
  - Expect rsp_hash and rsp_id stable, no new req_ready, and core_init low.
  - Raise rsp_ready: handshake, then the next grant on the following cycle.
- Skip and wrap: rr_ptr=3, req_valid=0101 → grant 0; next rr_ptr=1 → grant 2.
- Reset mid-WAIT: assert reset at cnt=30.
  - Expect no rsp_valid, all outputs at reset values.
  - A subsequent "abc" job returns the correct digest.
- Late request: req_valid[1] raised during WAIT of job 0.
  - Not granted until after job 0's response handshake, then granted on the next IDLE cycle.

Source files
------------

// File: rtl/sha256_core_arbiter.sv
// Round-robin arbiter sharing one SHA-256 block core among requesters.
// Define SHA_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration.
module sha256_core_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int CORE_LATENCY = 67,
  parameter int ID_W         = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*512-1:0] req_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [255:0]           rsp_hash,
  output logic [ID_W-1:0]        rsp_id,
  output logic [511:0]           core_data,
  output logic                   core_init,
  input  logic [255:0]           core_hash,
  output logic                   busy
);

  localparam int CW = $clog2(CORE_LATENCY + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CORE_LATENCY - 1);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;
  localparam logic [NUM_REQ-1:0] ONE =
    {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [ID_W-1:0] job_id;
  logic [ID_W-1:0] gnt;
  logic            found;

`ifdef SHA_ARB_FIXED_PRIO_EN
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        found = 1'b1;
        gnt   = ID_W'(i);
      end
    end
  end
`else
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);
  logic [ID_W-1:0] rr_ptr;

  // Search upward from rr_ptr, wrapping at NUM_REQ-1.
  always_comb begin
    int idx;
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt   = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (state == IDLE && found) begin
      rr_ptr <= (gnt == LAST_ID) ? '0 : gnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      job_id    <= '0;
      req_ready <= '0;
      rsp_valid <= 1'b0;
      rsp_hash  <= '0;
      rsp_id    <= '0;
      core_data <= '0;
      core_init <= 1'b0;
      busy      <= 1'b0;
    end else begin
      req_ready <= '0;
      core_init <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            req_ready <= ONE << gnt;
            core_data <= req_data[int'(gnt)*512 +: 512];
            job_id    <= gnt;
            core_init <= 1'b1;
            busy      <= 1'b1;
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            rsp_hash  <= core_hash;
            rsp_id    <= job_id;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
